cell_array_ctrl: RTL
====================

Name: cell_array_ctrl

Overview:
- Initiator side of the single-bit memory-cell interface (cs, rd_wr, wr_data -> rd_data).
- Accepts word-level read/write requests over a valid/ready handshake.
- Drives a DEPTH x WIDTH array of cells with correctly sequenced select, direction and data, then returns a one-cycle response.
- Sits between a host bus master and the cell array.

Parameters:
- WIDTH, 8: bits per word; one cell per bit.
- ADDR_W, 4: request address width.
- DEPTH, 12: number of implemented words; must be ≤ 2**ADDR_W.
- WR_PULSE, 2: cycles cs is held during a write; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  WIDTH  write data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  WIDTH  read data; 0 for writes.
- rsp_err  output  1  address out of range (or verify failure, see Optional Feature).
- cs  output  DEPTH  one-hot word select to the cell array.
- rd_wr  output  1  1 = read, 0 = write; shared by all cells.
- wr_data  output  WIDTH  bit-lane write data; shared by all words.
- rd_data  input  WIDTH  bit-lane read data; the array ORs the per-word outputs, so 0 when no word is selected.

Behaviour:
- Reset (rst=1 at an edge), applied next edge regardless of state:
  - state=IDLE, req_ready=1, cs=0, rd_wr=1, wr_data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Any in-flight request is dropped with no response.
- All outputs are registered.
- Idle bus: cs=0, rd_wr=1, wr_data=0. This bus can never write a cell.
- Handshake:
  - Transfer occurs at an edge with req_valid & req_ready.
  - addr, we and wdata are captured into internal registers at that edge.
  - req_ready=1 only in IDLE.
  - No response backpressure: rsp_valid is a one-cycle pulse.
- FSM:
  - IDLE: on transfer, go to SETUP if addr < DEPTH, else ERR.
  - SETUP (1 cycle): cs=0; rd_wr=~we; wr_data=wdata for writes, 0 for reads. Direction and data settle before any select. Go to ACCESS.
  - ACCESS:
    - cs[addr]=1 (one-hot), other bits 0; rd_wr and wr_data unchanged.
    - Write: held WR_PULSE cycles (down-counter loaded in SETUP).
    - Read: 1 cycle; rd_data is sampled into rsp_rdata at the edge ending ACCESS.
    - Then go to HOLD.
  - HOLD (1 cycle): cs=0; rd_wr and wr_data still held. Go to RESP.
  - RESP (1 cycle): rsp_valid=1, rsp_err=0, rsp_rdata = sampled data (reads) or 0 (writes). Bus returns to idle values. Go to IDLE.
  - ERR (1 cycle): cs stays 0; rsp_valid=1, rsp_err=1, rsp_rdata=0. Go to IDLE.
- Response timing:
  - rsp_valid/rsp_err/rsp_rdata are 0 in all states except RESP and ERR.
  - The response is visible on the outputs during the RESP/ERR cycle.
- Latency from the transfer edge to rsp_valid high:
  - Read: 4 cycles.
  - Write: 3+WR_PULSE cycles.
  - Out of range: 1 cycle.
- Back-to-back: a new request is accepted the cycle after RESP/ERR, when req_ready=1 again. Throughput for reads is 1 per 5 cycles.
- Invariants:
  - cs is never multi-hot.
  - cs is never asserted in the same cycle rd_wr or wr_data changes.
  - addr ≥ DEPTH never asserts any cs bit.

Optional Feature:
- Macro: CELL_ARRAY_CTRL_VERIFY_EN.
- Defined:
  - After a write's HOLD, insert VSETUP (rd_wr=1, wr_data=0, cs=0), then VREAD (cs[addr]=1 for 1 cycle, sample rd_data), then VHOLD (cs=0), then RESP.
  - rsp_err=1 if the sampled data ≠ wdata; rsp_rdata = sampled data.
  - Write latency becomes 6+WR_PULSE cycles.
- Undefined: no verify states; rsp_err only for out-of-range addresses.

Test Plan:
- Reset: rst high 2 cycles mid-write (in ACCESS) -> next cycle cs=0, rd_wr=1, req_ready=1, rsp_valid=0; no response ever issued for the dropped request.
- Write addr=3, wdata=8'hA5, WR_PULSE=2 -> SETUP rd_wr=0, wr_data=A5, cs=0; then cs=12'h008 for exactly 2 cycles; rsp_valid at transfer+5 with rsp_err=0, rsp_rdata=0.
- Read addr=3, model returns 8'hA5 while cs[3]=1 -> cs=12'h008 for 1 cycle with rd_wr=1; rsp_valid at transfer+4 with rsp_rdata=8'hA5.
- Out-of-range read addr=13 (DEPTH=12) -> cs stays 0; rsp_valid=1, rsp_err=1, rsp_rdata=0 at transfer+1.
- Back-to-back: write addr=0 data 8'h01, then read addr=11 held valid -> second transfer the cycle after the first RESP; cs never multi-hot; read returns the model value for word 11.
- With CELL_ARRAY_CTRL_VERIFY_EN, model bit 0 stuck at 0 and write 8'hFF to addr 5 -> one VREAD cs pulse on bit 5; rsp_err=1, rsp_rdata=8'hFE at transfer+8.

Source files
------------

// File: rtl/cell_array_ctrl.sv
// rtl/cell_array_ctrl.sv - word-level request front end sequencing select/direction/data onto a single-bit cell array
// Optional write read-back check is built when CELL_ARRAY_CTRL_VERIFY_EN is defined.
module cell_array_ctrl #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 12,
    parameter int WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic [DEPTH-1:0]  cs,
    output logic              rd_wr,
    output logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  rd_data
);

    localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_RESP,
`ifdef CELL_ARRAY_CTRL_VERIFY_EN
        S_VSETUP,
        S_VREAD,
        S_VHOLD,
`endif
        S_ERR
    } state_t;

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                we_q, we_n;
    logic [WIDTH-1:0]    wdata_q, wdata_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0]    sample_q, sample_n;

    logic                req_ready_n;
    logic [DEPTH-1:0]    cs_n;
    logic                rd_wr_n;
    logic [WIDTH-1:0]    wr_data_n;
    logic                rsp_valid_n;
    logic [WIDTH-1:0]    rsp_rdata_n;
    logic                rsp_err_n;
    logic                drive_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            sample_q  <= '0;
            req_ready <= 1'b1;
            cs        <= '0;
            rd_wr     <= 1'b1;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            we_q      <= we_n;
            wdata_q   <= wdata_n;
            cnt_q     <= cnt_n;
            sample_q  <= sample_n;
            req_ready <= req_ready_n;
            cs        <= cs_n;
            rd_wr     <= rd_wr_n;
            wr_data   <= wr_data_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        addr_n   = addr_q;
        we_n     = we_q;
        wdata_n  = wdata_q;
        cnt_n    = cnt_q;
        sample_n = sample_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_n  = req_addr;
                    we_n    = req_we;
                    wdata_n = req_wdata;
                    state_n = ({1'b0, req_addr} < DEPTH_L) ? S_SETUP : S_ERR;
                end
            end
            S_SETUP: begin
                cnt_n   = we_q ? CNT_W'(WR_PULSE - 1) : '0;
                state_n = S_ACCESS;
            end
            S_ACCESS: begin
                if (!we_q) begin
                    sample_n = rd_data;
                end
                if (cnt_q == '0) begin
                    state_n = S_HOLD;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
`ifdef CELL_ARRAY_CTRL_VERIFY_EN
            S_HOLD:   state_n = we_q ? S_VSETUP : S_RESP;
            S_VSETUP: state_n = S_VREAD;
            S_VREAD: begin
                sample_n = rd_data;
                state_n  = S_VHOLD;
            end
            S_VHOLD:  state_n = S_RESP;
`else
            S_HOLD:   state_n = S_RESP;
`endif
            S_RESP:   state_n = S_IDLE;
            S_ERR:    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain register.
    always_comb begin
        req_ready_n = (state_n == S_IDLE);
        drive_bus   = (state_n == S_SETUP) || (state_n == S_ACCESS) || (state_n == S_HOLD);
        rd_wr_n     = drive_bus ? ~we_n : 1'b1;
        wr_data_n   = (drive_bus && we_n) ? wdata_n : '0;
        cs_n        = '0;
`ifdef CELL_ARRAY_CTRL_VERIFY_EN
        if ((state_n == S_ACCESS) || (state_n == S_VREAD)) begin
            cs_n = DEPTH'(1) << addr_n;
        end
        rsp_rdata_n = (state_n == S_RESP) ? sample_n : '0;
        rsp_err_n   = (state_n == S_ERR) ||
                      ((state_n == S_RESP) && we_n && (sample_n != wdata_n));
`else
        if (state_n == S_ACCESS) begin
            cs_n = DEPTH'(1) << addr_n;
        end
        rsp_rdata_n = ((state_n == S_RESP) && !we_n) ? sample_n : '0;
        rsp_err_n   = (state_n == S_ERR);
`endif
        rsp_valid_n = (state_n == S_RESP) || (state_n == S_ERR);
    end

endmodule
